// File: rtl/comp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : comp_pkg
// Brief    : Shared types and constants for the magnitude comparator and the
//            comparison decoder that consumes its less/eql flags.
// Revision : 1.0 - initial release
// ============================================================================
package comp_pkg;

    localparam int c_def_width   = 32;
    localparam int c_def_digit_w = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } comp_state_t;

    // Decoder ctrl encodings; bit 1 is a don't-care for EQ/NE.
    localparam logic [2:0] c_ctrl_gt = 3'b000;
    localparam logic [2:0] c_ctrl_ge = 3'b001;
    localparam logic [2:0] c_ctrl_lt = 3'b010;
    localparam logic [2:0] c_ctrl_le = 3'b011;
    localparam logic [2:0] c_ctrl_eq = 3'b100;
    localparam logic [2:0] c_ctrl_ne = 3'b101;

    function automatic logic comp_decode(input logic [2:0] ctrl,
                                         input logic       less,
                                         input logic       eql);
        logic r;
        r = 1'b0;
        if (ctrl[2]) begin
            r = ctrl[0] ? ~eql : eql;
        end else begin
            case (ctrl[1:0])
                2'b00:   r = ~less & ~eql;
                2'b01:   r = ~less;
                2'b10:   r = less;
                default: r = less | eql;
            endcase
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/comp_enc_if.sv
`default_nettype none
// ============================================================================
// Module   : comp_enc_if
// Brief    : Start/busy/done handshake plus operand and flag bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface comp_enc_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             less_out;
    logic             eql_out;

    modport master (
        output start, signed_op, a, b,
        input  busy, done, less_out, eql_out
    );

    modport slave (
        input  start, signed_op, a, b,
        output busy, done, less_out, eql_out
    );
endinterface
`default_nettype wire

// File: rtl/comp_digit.sv
`default_nettype none
// ============================================================================
// Module   : comp_digit
// Brief    : Combinational unsigned compare of one DIGIT_W-bit digit pair.
// Revision : 1.0 - initial release
// ============================================================================
module comp_digit #(
    parameter int DIGIT_W = 4
) (
    input  wire logic [DIGIT_W-1:0] i_a,
    input  wire logic [DIGIT_W-1:0] i_b,
    output logic                    o_lt,
    output logic                    o_eq
);
    assign o_lt = (i_a < i_b);
    assign o_eq = (i_a == i_b);
endmodule
`default_nettype wire

// File: rtl/comp_enc.sv
`default_nettype none
// ============================================================================
// Module   : comp_enc
// Brief    : Digit-serial MSB-first magnitude comparator, signed or unsigned,
//            producing registered less/eql flags with start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module comp_enc
    import comp_pkg::*;
#(
    parameter int WIDTH   = c_def_width,
    parameter int DIGIT_W = c_def_digit_w
) (
    input  wire logic clk,
    input  wire logic rst,
    comp_enc_if.slave bus
);
    localparam int N     = WIDTH / DIGIT_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [WIDTH-1:0] c_sign_mask = {1'b1, {(WIDTH-1){1'b0}}};

    comp_state_t       r_state;
    comp_state_t       w_state_next;
    logic [WIDTH-1:0]  r_sa;
    logic [WIDTH-1:0]  r_sb;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_decided;
    logic              r_lt;
    logic              r_less;
    logic              r_eql;

    logic [WIDTH-1:0]  w_flip;
    logic              w_accept;
    logic              w_last;
    logic              w_dig_lt;
    logic              w_dig_eq;
    logic              w_decided_new;
    logic              w_lt_new;

    assign w_accept = bus.start && (r_state != RUN);
    assign w_last   = (r_state == RUN) && (r_cnt == CNT_W'(N - 1));
    assign w_flip   = bus.signed_op ? c_sign_mask : '0;

    comp_digit #(
        .DIGIT_W (DIGIT_W)
    ) u_digit (
        .i_a  (r_sa[WIDTH-1 -: DIGIT_W]),
        .i_b  (r_sb[WIDTH-1 -: DIGIT_W]),
        .o_lt (w_dig_lt),
        .o_eq (w_dig_eq)
    );

    // The first differing digit decides; later digits are ignored.
    assign w_decided_new = r_decided | ~w_dig_eq;
    assign w_lt_new      = r_decided ? r_lt : w_dig_lt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    w_state_next = bus.start ? RUN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sa      <= '0;
            r_sb      <= '0;
            r_cnt     <= '0;
            r_decided <= 1'b0;
            r_lt      <= 1'b0;
            r_less    <= 1'b0;
            r_eql     <= 1'b0;
        end else if (w_accept) begin
            r_sa      <= bus.a ^ w_flip;
            r_sb      <= bus.b ^ w_flip;
            r_cnt     <= '0;
            r_decided <= 1'b0;
            r_lt      <= 1'b0;
        end else if (r_state == RUN) begin
            r_sa      <= r_sa << DIGIT_W;
            r_sb      <= r_sb << DIGIT_W;
            r_cnt     <= r_cnt + CNT_W'(1);
            r_decided <= w_decided_new;
            r_lt      <= w_lt_new;
            if (w_last) begin
                r_less <= w_decided_new ? w_lt_new : 1'b0;
                r_eql  <= ~w_decided_new;
            end
        end
    end

    assign bus.busy     = (r_state == RUN);
    assign bus.done     = (r_state == DONE);
    assign bus.less_out = r_less;
    assign bus.eql_out  = r_eql;

endmodule
`default_nettype wire

// File: tb/tb_comp_enc.sv
`default_nettype none
// ============================================================================
// Module   : tb_comp_enc
// Brief    : Directed self-checking bench for the digit-serial comparator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_comp_enc;
    import comp_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    comp_enc_if #(.WIDTH(32)) bus ();

    comp_enc #(
        .WIDTH   (32),
        .DIGIT_W (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; start is sampled on the following posedge.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        bus.a         = a;
        bus.b         = b;
        bus.signed_op = s;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    // Negedges from the one after acceptance until done is seen (bounded).
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!bus.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.signed_op = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.less_out, bus.eql_out} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_state: busy/done/less/eql=%b required 0000",
                     {bus.busy, bus.done, bus.less_out, bus.eql_out});
        end
    endtask

    task automatic test_unsigned_basic;
        int cyc;
        launch(32'h0000_0005, 32'h0000_0007, 1'b0);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL busy_after_start: busy=%b required 1", bus.busy);
        end
        wait_done(cyc);
        n_checks++;
        if (cyc !== 8) begin
            n_fail++; $display("FAIL latency_5_7: cycles=%0d required 8", cyc);
        end
        n_checks++;
        if ({bus.less_out, bus.eql_out} !== 2'b10) begin
            n_fail++; $display("FAIL flags_5_7: less/eql=%b required 10", {bus.less_out, bus.eql_out});
        end
        @(negedge clk);
        n_checks++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            n_fail++; $display("FAIL done_single_pulse: done/busy=%b required 00", {bus.done, bus.busy});
        end
    endtask

    task automatic test_sign_modes;
        int cyc;
        launch(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        wait_done(cyc);
        n_checks++;
        if ({bus.less_out, bus.eql_out} !== 2'b10) begin
            n_fail++; $display("FAIL signed_m1_1: less/eql=%b required 10", {bus.less_out, bus.eql_out});
        end
        launch(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        wait_done(cyc);
        n_checks++;
        if ({bus.less_out, bus.eql_out} !== 2'b00) begin
            n_fail++; $display("FAIL unsigned_ff_1: less/eql=%b required 00", {bus.less_out, bus.eql_out});
        end
        for (int m = 0; m < 2; m++) begin
            launch(32'h8000_0000, 32'h8000_0000, m[0]);
            wait_done(cyc);
            n_checks++;
            if ({bus.less_out, bus.eql_out} !== 2'b01) begin
                n_fail++; $display("FAIL equal_8000_mode%0d: less/eql=%b required 01",
                                   m, {bus.less_out, bus.eql_out});
            end
        end
    endtask

    task automatic test_digit_edges;
        int cyc;
        launch(32'h1000_0000, 32'h2000_0000, 1'b0);
        wait_done(cyc);
        n_checks++;
        if (cyc !== 8 || {bus.less_out, bus.eql_out} !== 2'b10) begin
            n_fail++; $display("FAIL msb_digit: cycles=%0d less/eql=%b required 8 10",
                               cyc, {bus.less_out, bus.eql_out});
        end
        launch(32'h1234_5679, 32'h1234_5678, 1'b0);
        wait_done(cyc);
        n_checks++;
        if (cyc !== 8 || {bus.less_out, bus.eql_out} !== 2'b00) begin
            n_fail++; $display("FAIL lsb_bit: cycles=%0d less/eql=%b required 8 00",
                               cyc, {bus.less_out, bus.eql_out});
        end
    endtask

    task automatic test_start_while_busy;
        int cyc;
        launch(32'h0000_0007, 32'h0000_0007, 1'b0);
        wait_done(cyc);
        launch(32'h0000_0003, 32'h0000_0009, 1'b0);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.less_out, bus.eql_out} !== 2'b01) begin
            n_fail++; $display("FAIL hold_during_run: less/eql=%b required 01", {bus.less_out, bus.eql_out});
        end
        launch(32'h0000_0009, 32'h0000_0003, 1'b1);
        bus.a = 32'hFFFF_FFFF;
        wait_done(cyc);
        n_checks++;
        if ({bus.less_out, bus.eql_out} !== 2'b10) begin
            n_fail++; $display("FAIL ignore_busy_start: less/eql=%b required 10", {bus.less_out, bus.eql_out});
        end
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            n_fail++; $display("FAIL no_queued_start: busy/done=%b required 00", {bus.busy, bus.done});
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        int held_bad;
        launch(32'd10, 32'd20, 1'b0);
        wait_done(cyc);
        launch(32'd20, 32'd10, 1'b0);
        held_bad = 0;
        cyc = 1;
        while (!bus.done && cyc < 40) begin
            if ({bus.less_out, bus.eql_out} !== 2'b10) held_bad++;
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc !== 9) begin
            n_fail++; $display("FAIL b2b_gap: cycles=%0d required 9", cyc);
        end
        n_checks++;
        if (held_bad !== 0) begin
            n_fail++; $display("FAIL b2b_old_flags_hold: bad_cycles=%0d required 0", held_bad);
        end
        n_checks++;
        if ({bus.less_out, bus.eql_out} !== 2'b00) begin
            n_fail++; $display("FAIL b2b_new_flags: less/eql=%b required 00", {bus.less_out, bus.eql_out});
        end
    endtask

    task automatic test_reset_midrun;
        int cyc;
        int dones;
        launch(32'h0000_0042, 32'h0000_0042, 1'b0);
        wait_done(cyc);
        launch(32'h0000_0001, 32'h0000_0002, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.less_out, bus.eql_out} !== 4'b0000) begin
            n_fail++; $display("FAIL async_reset: busy/done/less/eql=%b required 0000",
                               {bus.busy, bus.done, bus.less_out, bus.eql_out});
        end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++; $display("FAIL no_done_after_reset: active_cycles=%0d required 0", dones);
        end
        launch(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0);
        wait_done(cyc);
        n_checks++;
        if (cyc !== 8 || {bus.less_out, bus.eql_out} !== 2'b10) begin
            n_fail++; $display("FAIL fresh_after_reset: cycles=%0d less/eql=%b required 8 10",
                               cyc, {bus.less_out, bus.eql_out});
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_unsigned_basic();
        test_sign_modes();
        test_digit_edges();
        test_start_while_busy();
        test_back_to_back();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
